// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave backed by a 2**ADDR_W x 32-bit word memory.
// The read and write channels run as independent FSMs; out-of-range addresses return SLVERR.
module axi_lite_slave_mem #(
  parameter int ADDR_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] AWADDR,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic [31:0] ARADDR,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RVALID,
  input  logic        RREADY
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;

  r_state_t r_state;
  w_state_t w_state;

  logic [31:0] mem [DEPTH];

  logic        aw_held;
  logic        w_held;
  logic [31:0] aw_addr;
  logic [31:0] w_data;
  logic [3:0]  w_strb;

  logic        aw_hs;
  logic        w_hs;
  logic        commit;
  logic [31:0] eff_addr;
  logic [31:0] eff_data;
  logic [3:0]  eff_strb;

  // Only the low ADDR_W+2 address bits may be set for an in-range access.
  function automatic logic in_range(input logic [31:0] addr);
    return (addr >> (ADDR_W + 2)) == 32'd0;
  endfunction

  // Ready/valid strobes come from registered state only, never from VALID inputs.
  assign ARREADY = (r_state == R_IDLE);
  assign RVALID  = (r_state == R_DATA);
  assign AWREADY = (w_state == W_IDLE) && !aw_held;
  assign WREADY  = (w_state == W_IDLE) && !w_held;
  assign BVALID  = (w_state == W_RESP);

  always_comb begin
    aw_hs    = AWVALID && AWREADY;
    w_hs     = WVALID && WREADY;
    eff_addr = aw_held ? aw_addr : AWADDR;
    eff_data = w_held ? w_data : WDATA;
    eff_strb = w_held ? w_strb : WSTRB;
    commit   = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
  end

  always_ff @(posedge clk) begin
    if (!rst && commit && in_range(eff_addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (eff_strb[b]) begin
          mem[eff_addr[ADDR_W+1:2]][8*b +: 8] <= eff_data[8*b +: 8];
        end
      end
    end
  end

  // Reading mem here sees the pre-write value when a commit hits the same word on this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      RDATA   <= 32'd0;
      RRESP   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARVALID) begin
            RDATA   <= in_range(ARADDR) ? mem[ARADDR[ADDR_W+1:2]] : 32'd0;
            RRESP   <= in_range(ARADDR) ? RESP_OKAY : RESP_SLVERR;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            r_state <= R_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= 32'd0;
      w_data  <= 32'd0;
      w_strb  <= 4'd0;
      BRESP   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (commit) begin
            BRESP   <= in_range(eff_addr) ? RESP_OKAY : RESP_SLVERR;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            w_state <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_held <= 1'b1;
              aw_addr <= AWADDR;
            end
            if (w_hs) begin
              w_held <= 1'b1;
              w_data <= WDATA;
              w_strb <= WSTRB;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            w_state <= W_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Directed testbench for axi_lite_slave_mem: every DUT output is compared against hand-computed values.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_axi_lite_slave_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int compareCount = 0;
  int failCount = 0;

  axi_lite_slave_mem #(.ADDR_W(6)) dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  // AW and W presented together; the response must appear the next cycle and retire one cycle later.
  task automatic doWrite(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [1:0] expResp);
    AWADDR = addr; WDATA = data; WSTRB = strb;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    checkOutput({tag, "_bvalid"}, 32'(BVALID), 32'd1);
    checkOutput({tag, "_bresp"}, 32'(BRESP), 32'(expResp));
    tick();
    checkOutput({tag, "_bdone"}, 32'(BVALID), 32'd0);
  endtask

  task automatic doRead(input string tag, input logic [31:0] addr, input logic [31:0] expData,
                        input logic [1:0] expResp);
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
    tick();
    ARVALID = 1'b0;
    checkOutput({tag, "_rvalid"}, 32'(RVALID), 32'd1);
    checkOutput({tag, "_rdata"}, RDATA, expData);
    checkOutput({tag, "_rresp"}, 32'(RRESP), 32'(expResp));
    tick();
    checkOutput({tag, "_rdone"}, 32'(RVALID), 32'd0);
    checkOutput({tag, "_arready"}, 32'(ARREADY), 32'd1);
  endtask

  initial begin
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b1; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b1;
    #2;
    applyReset(2);

    $display("[TB] reset state");
    checkOutput("rst_awready", 32'(AWREADY), 32'd1);
    checkOutput("rst_wready", 32'(WREADY), 32'd1);
    checkOutput("rst_arready", 32'(ARREADY), 32'd1);
    checkOutput("rst_rvalid", 32'(RVALID), 32'd0);
    checkOutput("rst_bvalid", 32'(BVALID), 32'd0);
    checkOutput("rst_rdata", RDATA, 32'd0);
    checkOutput("rst_rresp", 32'(RRESP), 32'd0);
    checkOutput("rst_bresp", 32'(BRESP), 32'd0);

    $display("[TB] simultaneous AW/W write then read back");
    doWrite("wr10", 32'h10, 32'hDEADBEEF, 4'b1111, 2'b00);
    doRead("rd10", 32'h10, 32'hDEADBEEF, 2'b00);

    $display("[TB] W three cycles ahead of AW with partial strobes");
    WDATA = 32'h11223344; WSTRB = 4'b0101; WVALID = 1'b1; BREADY = 1'b0;
    tick();
    WVALID = 1'b0;
    checkOutput("early_w_wready0", 32'(WREADY), 32'd0);
    checkOutput("early_w_awready", 32'(AWREADY), 32'd1);
    checkOutput("early_w_nobvalid", 32'(BVALID), 32'd0);
    tick();
    checkOutput("early_w_wready1", 32'(WREADY), 32'd0);
    tick();
    checkOutput("early_w_wready2", 32'(WREADY), 32'd0);
    AWADDR = 32'h10; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    checkOutput("early_w_bvalid", 32'(BVALID), 32'd1);
    checkOutput("early_w_bresp", 32'(BRESP), 32'd0);
    checkOutput("early_w_wready3", 32'(WREADY), 32'd0);
    checkOutput("early_w_awready_resp", 32'(AWREADY), 32'd0);
    tick();
    checkOutput("early_w_bhold", 32'(BVALID), 32'd1);
    checkOutput("early_w_wready4", 32'(WREADY), 32'd0);
    BREADY = 1'b1;
    tick();
    checkOutput("early_w_bdone", 32'(BVALID), 32'd0);
    checkOutput("early_w_wready_back", 32'(WREADY), 32'd1);
    doRead("rd_merge", 32'h10, 32'hDE22BE44, 2'b00);

    $display("[TB] out-of-range accesses");
    doWrite("wr00", 32'h00, 32'h12345678, 4'b1111, 2'b00);
    doRead("rd_oob", 32'h100, 32'h0, 2'b10);
    doWrite("wr_oob", 32'h100, 32'hFFFFFFFF, 4'b1111, 2'b10);
    doRead("rd00_intact", 32'h00, 32'h12345678, 2'b00);

    $display("[TB] zero strobe write");
    doWrite("wr_nostrb", 32'h00, 32'hAAAAAAAA, 4'b0000, 2'b00);
    doRead("rd_nostrb", 32'h00, 32'h12345678, 2'b00);

    $display("[TB] read backpressure");
    ARADDR = 32'h10; ARVALID = 1'b1; RREADY = 1'b0;
    tick();
    ARVALID = 1'b0;
    checkOutput("bp_rvalid", 32'(RVALID), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("bp_rvalid_%0d", i), 32'(RVALID), 32'd1);
      checkOutput($sformatf("bp_rdata_%0d", i), RDATA, 32'hDE22BE44);
      checkOutput($sformatf("bp_arready_%0d", i), 32'(ARREADY), 32'd0);
    end
    RREADY = 1'b1;
    tick();
    checkOutput("bp_rdone", 32'(RVALID), 32'd0);
    checkOutput("bp_arready_back", 32'(ARREADY), 32'd1);

    $display("[TB] same-edge read and write to one word");
    doWrite("wr20_clear", 32'h20, 32'h0, 4'b1111, 2'b00);
    ARADDR = 32'h20; ARVALID = 1'b1; RREADY = 1'b1;
    AWADDR = 32'h20; WDATA = 32'hA5A5A5A5; WSTRB = 4'b1111;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    tick();
    ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
    checkOutput("coll_rvalid", 32'(RVALID), 32'd1);
    checkOutput("coll_rdata_old", RDATA, 32'h0);
    checkOutput("coll_bvalid", 32'(BVALID), 32'd1);
    tick();
    doRead("coll_rdata_new", 32'h20, 32'hA5A5A5A5, 2'b00);

    $display("[TB] reset with a pending write response");
    AWADDR = 32'h30; WDATA = 32'h0BADF00D; WSTRB = 4'b1111;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    checkOutput("rstb_bvalid", 32'(BVALID), 32'd1);
    applyReset(1);
    checkOutput("rstb_bvalid_cleared", 32'(BVALID), 32'd0);
    checkOutput("rstb_awready", 32'(AWREADY), 32'd1);
    doWrite("rstb_wr", 32'h30, 32'hCAFEF00D, 4'b1111, 2'b00);
    doRead("rstb_rd", 32'h30, 32'hCAFEF00D, 2'b00);

    $display("[TB] reset discards latched write data");
    WDATA = 32'h55555555; WSTRB = 4'b1111; WVALID = 1'b1; BREADY = 1'b1;
    tick();
    WVALID = 1'b0;
    applyReset(1);
    checkOutput("rstw_wready", 32'(WREADY), 32'd1);
    AWADDR = 32'h30; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    checkOutput("rstw_no_commit", 32'(BVALID), 32'd0);
    WDATA = 32'h600DCAFE; WSTRB = 4'b1111; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    checkOutput("rstw_bvalid", 32'(BVALID), 32'd1);
    checkOutput("rstw_bresp", 32'(BRESP), 32'd0);
    tick();
    checkOutput("rstw_bdone", 32'(BVALID), 32'd0);
    doRead("rstw_rd", 32'h30, 32'h600DCAFE, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_mem.md
AXI_LITE_SLAVE_MEM -- requirements
Module: axi_lite_slave_mem

Interface
REQ-001 Parameter ADDR_W, 6, word-index width; memory holds 2**ADDR_W 32-bit words (64 words = 256 bytes at the default).
REQ-002 Port clk  in  1  sole clock; every register updates on its rising edge.
REQ-003 Port rst  in  1  reset, synchronous and active-high.
REQ-004 Port AWADDR  in  32  write byte address.
REQ-005 Port AWVALID  in  1  write address valid.
REQ-006 Port AWREADY  out  1  write address accepted.
REQ-007 Port WDATA  in  32  write data.
REQ-008 Port WSTRB  in  4  byte enables; bit i qualifies WDATA[8i+7:8i].
REQ-009 Port WVALID  in  1  write data valid.
REQ-010 Port WREADY  out  1  write data accepted.
REQ-011 Port BRESP  out  2  write response: 00 = OKAY, 10 = SLVERR.
REQ-012 Port BVALID  out  1  write response valid.
REQ-013 Port BREADY  in  1  master accepts the write response.
REQ-014 Port ARADDR  in  32  read byte address.
REQ-015 Port ARVALID  in  1  read address valid.
REQ-016 Port ARREADY  out  1  read address accepted.
REQ-017 Port RDATA  out  32  read data.
REQ-018 Port RRESP  out  2  read response: 00 = OKAY, 10 = SLVERR.
REQ-019 Port RVALID  out  1  read data valid.
REQ-020 Port RREADY  in  1  master accepts the read data.

Function
REQ-021 Address decode: word index = ADDR[ADDR_W+1:2]; ADDR[1:0] ignored; in range iff ADDR[31:ADDR_W+2] == 0; otherwise SLVERR.
REQ-022 Read and write paths are independent FSMs and run concurrently.
REQ-023 Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY = 1.
  - On ARVALID && ARREADY: register RDATA = mem[index], or 0 if out of range; set RRESP; go to R_DATA.
  - RVALID = 1 in the cycle after the handshake.
REQ-024 R_DATA: RVALID = 1, ARREADY = 0; RDATA/RRESP held stable until RVALID && RREADY, then return to R_IDLE.
  - Back-to-back reads: one read every 2 cycles minimum.
REQ-025 Write FSM states: W_IDLE, W_RESP; W_IDLE keeps flags aw_held and w_held.
REQ-026 W_IDLE ready signals:
  - AWREADY = !aw_held; WREADY = !w_held.
  - An AW or W handshake latches its address or data+strobe and sets the matching flag; AW and W are accepted in either order or in the same cycle.
REQ-027 Write commit: on the edge where both address and data are available (latched or handshaking that cycle):
  - write mem[index] byte-wise for WSTRB bits set; no write if out of range;
  - set BRESP; clear both flags; enter W_RESP.
  - BVALID = 1 in the next cycle.
REQ-028 W_RESP: BVALID = 1, AWREADY = WREADY = 0; BRESP held until BVALID && BREADY, then return to W_IDLE.
REQ-029 WSTRB = 0000 with an in-range address: no byte changes; BRESP = OKAY.
REQ-030 Read/write collision: if the AR handshake and a write commit to the same word occur on the same edge, RDATA returns the pre-write value.
REQ-031 READY outputs are decoded from registered state only; there is no combinational path from any VALID input to any READY output.
REQ-032 A master may drop RREADY/BREADY and re-assert it later; the slave holds VALID until the handshake, with no timeout.

Reset
REQ-033 While rst = 1 at a clock edge:
  - both FSMs return to idle; flags are cleared;
  - RVALID = BVALID = 0; RDATA = 0; RRESP = BRESP = 00;
  - AWREADY = WREADY = ARREADY = 1 from the first cycle after reset.
REQ-034 Reset mid-transaction discards pending responses and latched AW/W; memory contents are not cleared by reset.

Verification
REQ-035 Write AWADDR = 0x10, WDATA = 0xDEADBEEF, WSTRB = 1111, AW and W in the same cycle -> BVALID next cycle, BRESP = 00; then read 0x10 -> RDATA = 0xDEADBEEF, RRESP = 00.
REQ-036 W issued 3 cycles before AW, WDATA = 0x11223344, WSTRB = 0101, to a word holding 0xDEADBEEF -> word becomes 0xDE22BE44; WREADY = 0 from the W handshake until BVALID && BREADY completes.
REQ-037 Read ARADDR = 0x100 with ADDR_W = 6 -> RRESP = 10, RDATA = 0; write to 0x100 -> BRESP = 10, memory unchanged.
REQ-038 Master holds RREADY = 0 for 5 cycles after RVALID -> RVALID and RDATA stable for all 5 cycles; ARREADY = 0 throughout; ARREADY = 1 the cycle after the handshake.
REQ-039 Same-edge AR and write commit to 0x20 (old 0x0, new 0xA5A5A5A5) -> read returns 0x0; the next read returns 0xA5A5A5A5.
REQ-040 rst pulsed while BVALID = 1 -> BVALID = 0 after the reset edge; the next write/read pair completes normally.
